// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-side bus controller:
// FSM state encoding, MMIO register offsets and the fault read pattern.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Byte offsets of the MMIO registers relative to the MMIO window base
  localparam logic [31:0] CON_TX = 32'h0000_0000;
  localparam logic [31:0] STATUS = 32'h0000_0004;
  localparam logic [31:0] CYCLES = 32'h0000_0008;

  // Read pattern returned for any unmapped or illegal access
  localparam logic [31:0] FAULT_RDATA = 32'hDEAD_BEEF;

  // Assemble the status word seen by software at MMIO_BASE+4
  function automatic logic [31:0] pack_status(input logic [7:0] count,
                                              input logic       full,
                                              input logic       empty);
    return {16'b0, count, 6'b0, full, empty};
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_fifo.sv
// Console transmit FIFO: 8-bit entries, DEPTH a power of two.
// Pushes while full and pops while empty are ignored. A pop does not
// make room for a push in the same cycle because full is taken from the
// registered count. The head byte reads as zero whenever the FIFO is empty.
module console_fifo #(
  parameter int  DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [7:0]    push_data,
  output logic          full,
  input  logic          pop,
  output logic [7:0]    head_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = empty ? 8'h00 : fifo_mem[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer and count registers, emptied by reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (resetn && do_push) begin
      fifo_mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side slave for the multicycle core: word RAM with byte-lane
// strobes, programmable wait states and a small MMIO window holding the
// console TX FIFO, a status word and a free-running cycle counter.
// mem_ready is registered, so it appears one cycle after the ACCESS state.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int          MEM_WORDS   = 4096,
  parameter int          WAIT_STATES = 1,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        fault
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [31:0] CON_ADDR  = MMIO_BASE + CON_TX;
  localparam logic [31:0] STAT_ADDR = MMIO_BASE + STATUS;
  localparam logic [31:0] CYC_ADDR  = MMIO_BASE + CYCLES;

  state_e        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          instr_q, instr_d;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          fault_q, fault_d;
  logic [31:0]   cycles_q, cycles_d;

  logic [31:0]   ram [MEM_WORDS];

  logic [31:0]   aligned_addr;
  logic [AW-1:0] ram_index;
  logic          is_ram, is_con, is_stat, is_cyc, is_bad;
  logic          ram_we;
  logic          con_push_req, con_stall;
  logic [31:0]   access_rdata;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;

  assign aligned_addr = addr_q & 32'hFFFF_FFFC;
  assign ram_index    = aligned_addr[AW+1:2];

  // Address decode of the latched request; MMIO is data-only
  always_comb begin
    is_ram  = (aligned_addr < RAM_BYTES);
    is_con  = !is_ram && !instr_q && (aligned_addr == CON_ADDR);
    is_stat = !is_ram && !instr_q && (aligned_addr == STAT_ADDR);
    is_cyc  = !is_ram && !instr_q && (aligned_addr == CYC_ADDR);
    is_bad  = !is_ram && !is_con && !is_stat && !is_cyc;
  end

  // Side effects of the ACCESS cycle: RAM write enable and console push
  always_comb begin
    ram_we       = (state_q == ACCESS) && is_ram && (wstrb_q != 4'b0000);
    con_push_req = (state_q == ACCESS) && is_con && wstrb_q[0];
    con_stall    = con_push_req && fifo_full;
    fifo_push    = con_push_req && !fifo_full;
    fifo_pop     = !fifo_empty && con_ready;
  end

  // Read data mux for the current access target
  always_comb begin
    access_rdata = 32'h0;
    if (is_ram) begin
      access_rdata = ram[ram_index];
    end else if (is_stat) begin
      access_rdata = pack_status(8'(fifo_count), fifo_full, fifo_empty);
    end else if (is_cyc) begin
      access_rdata = cycles_q;
    end else if (is_bad) begin
      access_rdata = FAULT_RDATA;
    end
  end

  // Transaction FSM: latch request, count wait states, access, await release
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    instr_d    = instr_q;
    ready_d    = 1'b0;
    rdata_d    = 32'h0;
    fault_d    = fault_q;
    cycles_d   = cycles_q + 32'd1;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d     = mem_addr;
          wdata_d    = mem_wdata;
          wstrb_d    = mem_wstrb;
          instr_d    = mem_instr;
          wait_cnt_d = WAIT_INIT;
          state_d    = (WAIT_INIT != 4'd0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q <= 4'd1) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!con_stall) begin
          ready_d = 1'b1;
          rdata_d = access_rdata;
          state_d = DONE;
          if (is_bad) begin
            fault_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (!mem_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      instr_q    <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= 32'h0;
      fault_q    <= 1'b0;
      cycles_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      instr_q    <= instr_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
      cycles_q   <= cycles_d;
    end
  end

  // RAM byte-lane writes; never written on a reset edge
  always_ff @(posedge clk) begin
    if (resetn && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          ram[ram_index][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  console_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_console_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (wdata_q[7:0]),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign fault     = fault_q;
  assign con_data  = fifo_head;
  assign con_valid = !fifo_empty;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: RAM and byte lanes, console FIFO with
// full stall, status and cycle counter, unmapped accesses, held valid and
// reset in the middle of a transaction. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_mem_bus_ctrl;

  localparam logic [31:0] MMIO = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready = 1'b0;
  logic        fault;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(
    .MEM_WORDS   (4096),
    .WAIT_STATES (1),
    .FIFO_DEPTH  (8),
    .MMIO_BASE   (MMIO)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .con_data  (con_data),
    .con_valid (con_valid),
    .con_ready (con_ready),
    .fault     (fault)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete bus transaction; checks completion and the two-cycle latency
  task automatic applyStimulus(input string tag, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               input logic instr, output logic [31:0] rdata);
    int cycles;
    cycles = 0;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_instr = instr;
    do begin
      @(negedge clk);
      cycles++;
    end while (!mem_ready && cycles < 40);
    checkOutput({tag, "_ready"}, 32'(mem_ready), 32'h1);
    checkOutput({tag, "_lat"}, 32'(cycles - 1), 32'd2);
    rdata     = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    mem_instr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] c1;
    logic [31:0] c2;
    logic [8:0]  exp9;
    int          pulses;
    int          cycles;

    // Reset state
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(mem_ready), 32'h0);
    checkOutput("rst_rdata", mem_rdata, 32'h0);
    checkOutput("rst_fault", 32'(fault), 32'h0);
    checkOutput("rst_con_valid", 32'(con_valid), 32'h0);
    checkOutput("rst_con_data", 32'(con_data), 32'h0);
    resetn = 1'b1;

    // RAM write/read and byte lanes
    applyStimulus("wr40", 32'h40, 32'hA5A5_1234, 4'hF, 1'b0, rd);
    applyStimulus("rd40", 32'h40, 32'h0, 4'h0, 1'b0, rd);
    checkOutput("rd40_data", rd, 32'hA5A5_1234);
    applyStimulus("wr80", 32'h80, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
    applyStimulus("wr80b", 32'h80, 32'h0000_5500, 4'b0010, 1'b0, rd);
    applyStimulus("rd80", 32'h80, 32'h0, 4'h0, 1'b0, rd);
    checkOutput("rd80_data", rd, 32'hFFFF_55FF);

    // Last RAM word, including an unaligned alias of it
    applyStimulus("wrtop", 32'h3FFC, 32'h1357_9BDF, 4'hF, 1'b0, rd);
    applyStimulus("rdtop", 32'h3FFF, 32'h0, 4'h0, 1'b0, rd);
    checkOutput("rdtop_data", rd, 32'h1357_9BDF);
    checkOutput("rdtop_fault", 32'(fault), 32'h0);

    // Console with a ready sink
    con_ready = 1'b1;
    applyStimulus("con48", MMIO, 32'h0000_0048, 4'h1, 1'b0, rd);
    checkOutput("con48_valid", 32'(con_valid), 32'h1);
    checkOutput("con48_data", 32'(con_data), 32'h48);
    applyStimulus("con49", MMIO, 32'h0000_0049, 4'h1, 1'b0, rd);
    checkOutput("con49_data", 32'(con_data), 32'h49);
    applyStimulus("stat_empty", MMIO + 32'h4, 32'h0, 4'h0, 1'b0, rd);
    checkOutput("stat_empty_data", rd, 32'h0000_0001);

    // Fill the FIFO with the sink stalled
    con_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("fill%0d", i), MMIO, 32'(8'h30 + i), 4'h1, 1'b0, rd);
    end
    applyStimulus("stat_full", MMIO + 32'h4, 32'h0, 4'h0, 1'b0, rd);
    checkOutput("stat_full_data", rd, 32'h0000_0802);
    checkOutput("full_head", 32'(con_data), 32'h30);

    // Ninth push stalls until one pop frees an entry
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = MMIO;
    mem_wdata = 32'h0000_0038;
    mem_wstrb = 4'h1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_ready) pulses++;
    end
    checkOutput("stall_noready", 32'(pulses), 32'h0);
    con_ready = 1'b1;
    @(negedge clk);
    con_ready = 1'b0;
    cycles = 0;
    while (!mem_ready && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("stall_ready", 32'(mem_ready), 32'h1);
    checkOutput("stall_release_lat", 32'(cycles), 32'd1);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    checkOutput("stall_head", 32'(con_data), 32'h31);
    applyStimulus("stat_full2", MMIO + 32'h4, 32'h0, 4'h0, 1'b0, rd);
    checkOutput("stat_full2_data", rd, 32'h0000_0802);

    // Drain in order
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp9 = {1'b1, 8'(8'h31 + i)};
      checkOutput($sformatf("drain%0d", i), 32'({con_valid, con_data}), 32'(exp9));
      @(negedge clk);
    end
    checkOutput("drain_empty", 32'(con_valid), 32'h0);
    con_ready = 1'b0;

    // Unmapped accesses and sticky fault
    applyStimulus("unmap", 32'h2000_0000, 32'h0, 4'h0, 1'b0, rd);
    checkOutput("unmap_data", rd, 32'hDEAD_BEEF);
    checkOutput("unmap_fault", 32'(fault), 32'h1);
    applyStimulus("after_fault", 32'h40, 32'h0, 4'h0, 1'b0, rd);
    checkOutput("after_fault_data", rd, 32'hA5A5_1234);
    checkOutput("after_fault_sticky", 32'(fault), 32'h1);
    applyStimulus("ram_end", 32'h4000, 32'h0, 4'h0, 1'b0, rd);
    checkOutput("ram_end_data", rd, 32'hDEAD_BEEF);
    applyStimulus("ifetch_mmio", MMIO + 32'h8, 32'h0, 4'h0, 1'b1, rd);
    checkOutput("ifetch_mmio_data", rd, 32'hDEAD_BEEF);

    // Cycle counter advances by the spacing of back-to-back accesses
    applyStimulus("cyc1", MMIO + 32'h8, 32'h0, 4'h0, 1'b0, c1);
    applyStimulus("cyc2", MMIO + 32'h8, 32'h0, 4'h0, 1'b0, c2);
    checkOutput("cyc_delta", c2 - c1, 32'd4);

    // Held valid yields exactly one ready pulse
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h80;
    mem_wstrb = 4'h0;
    pulses = 0;
    rd = 32'h0;
    repeat (8) begin
      @(negedge clk);
      if (mem_ready) begin
        pulses++;
        rd = mem_rdata;
      end
    end
    mem_valid = 1'b0;
    checkOutput("held_pulses", 32'(pulses), 32'd1);
    checkOutput("held_data", rd, 32'hFFFF_55FF);
    applyStimulus("after_held", 32'h3FFC, 32'h0, 4'h0, 1'b0, rd);
    checkOutput("after_held_data", rd, 32'h1357_9BDF);

    // Reset while a write sits in WAIT
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h40;
    mem_wdata = 32'h1111_1111;
    mem_wstrb = 4'hF;
    @(negedge clk);
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(negedge clk);
    checkOutput("rst_mid_ready", 32'(mem_ready), 32'h0);
    resetn = 1'b1;
    applyStimulus("cyc_rst", MMIO + 32'h8, 32'h0, 4'h0, 1'b0, rd);
    checkOutput("cyc_rst_data", rd, 32'd3);
    checkOutput("rst_fault_clear", 32'(fault), 32'h0);
    applyStimulus("rd40_rst", 32'h40, 32'h0, 4'h0, 1'b0, rd);
    checkOutput("rd40_rst_data", rd, 32'hA5A5_1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory-side slave that serves the multicycle RISC-V core's memory port: instruction fetches, loads and stores.
- Contains a word-organised RAM with byte-lane write strobes, configurable wait states, and a small MMIO region.
- MMIO region provides a console TX FIFO, a status word and a free-running cycle counter.
- Sits directly downstream of the core; replaces the bare testbench memory model.

Parameters:
- MEM_WORDS, 4096: RAM depth in 32-bit words; RAM occupies byte addresses 0 .. MEM_WORDS*4-1.
- WAIT_STATES, 1: extra cycles inserted before mem_ready (0..15).
- FIFO_DEPTH, 8: console FIFO entries, power of two.
- MMIO_BASE, 32'h1000_0000: base byte address of the MMIO window.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- mem_valid  in  1  core request valid; held until mem_ready
- mem_instr  in  1  request is an instruction fetch (informational; fetches to MMIO fault)
- mem_addr  in  32  byte address; bits [1:0] ignored (word access)
- mem_wdata  in  32  store data, lane-aligned by the core
- mem_wstrb  in  4  byte write enables; 0 = read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- con_data  out  8  console FIFO head byte
- con_valid  out  1  FIFO non-empty
- con_ready  in  1  sink accepts head byte
- fault  out  1  sticky: unmapped access seen

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE; mem_ready=0, mem_rdata=0, fault=0, cycle counter=0.
  - FIFO emptied (con_valid=0, con_data=0).
  - RAM contents not cleared.
  - Reset mid-transaction aborts it with no ready pulse and no RAM write.
- FSM states: IDLE, WAIT, ACCESS, DONE.
  - IDLE: on mem_valid=1, latch addr/wdata/wstrb/instr and load the wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else ACCESS.
  - WAIT: decrement counter; go to ACCESS when counter reaches 1.
  - ACCESS: perform the access and pulse mem_ready=1 with mem_rdata for exactly one cycle, then go to DONE. The one exception is the console stall below.
  - DONE: wait for mem_valid=0, then go to IDLE. This prevents double-accepting a held request.
- Latency: request sampled in IDLE at edge t; mem_ready high in cycle t+1+WAIT_STATES.
- Address decode (uses the latched address):
  - RAM: addr < MEM_WORDS*4. Read returns the whole word. Write updates only the lanes with wstrb[i]=1.
  - MMIO_BASE+0, console TX:
    - Write with wstrb[0]=1 pushes wdata[7:0].
    - If the FIFO is full, stay in ACCESS with mem_ready=0 until a pop frees an entry.
    - A pop in the same cycle does not free space for that cycle; the push completes the following cycle.
    - Reads return 0.
  - MMIO_BASE+4, status (read-only): {16'b0, count[7:0], 6'b0, full, empty}. Writes are ignored and complete normally.
  - MMIO_BASE+8, cycle counter (read-only, 32-bit): increments every cycle out of reset and wraps at 2^32. The value returned is the one sampled in the ACCESS cycle.
  - Anything else, or an instruction fetch to MMIO:
    - Completes normally with mem_rdata=32'hDEAD_BEEF.
    - Writes are dropped.
    - fault sets and stays set until reset.
- FIFO:
  - Pop when con_valid && con_ready.
  - con_data always shows the head entry.
  - Pointers wrap modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH.

Decomposition:
- Package mem_bus_pkg holds:
  - the state enum {IDLE, WAIT, ACCESS, DONE};
  - MMIO offsets CON_TX=0, STATUS=4, CYCLES=8;
  - FAULT_RDATA=32'hDEAD_BEEF.
- Sub-module console_fifo (8-bit synchronous FIFO) with push/full/pop/empty/count ports.

Test Plan:
- RAM write then read, WAIT_STATES=1: write 32'hA5A5_1234 to 0x40 with wstrb=4'hF, then read 0x40 -> mem_ready 2 cycles after valid is sampled; rdata=32'hA5A5_1234.
- Byte lanes: over 32'hFFFF_FFFF at 0x80, write 32'h0000_5500 with wstrb=4'b0010 -> read returns 32'hFFFF_55FF.
- Console: write 0x48 and 0x49 to MMIO_BASE with con_ready=1 -> con_data shows 0x48 then 0x49; status reads 0x0000_0001 afterwards.
- FIFO full stall, con_ready=0: nine console writes -> the ninth is held with mem_ready=0 until con_ready pulses once; status before the ninth write = 0x0000_0802.
- Unmapped access: read 0x2000_0000 -> rdata=32'hDEAD_BEEF and fault=1 persists; a following RAM access completes normally.
- Held valid and reset: keep mem_valid high for 5 cycles after mem_ready -> exactly one ready pulse. Assert resetn=0 during WAIT -> no mem_ready, target RAM word unchanged, cycle counter restarts from 0.
